laser310_dn_arbiter: RTL and testbench
======================================

// Module: laser310_dn_arbiter
// PURPOSE
//  Shares the single-port system RAM between the Z80 CPU and the HPS ioctl download stream.
//  Download bytes pass through a 1-deep holding register, with back-pressure on ioctl_wait.
//  Fair round-robin arbitration between the two requesters. Reports download completion
//  (byte count, overrun). Sits between the emu top level and LASER310_TOP memory.
// PARAMETERS
//  DN_INDEX  8'h00     ioctl_index value accepted; all other indexes are dropped silently
//  DN_BASE   16'h0000  RAM address of download byte 0
//  DN_SIZE   17'h10000 bytes accepted; bytes with ioctl_addr >= DN_SIZE are dropped
// PORTS
//  clk_sys        in   1   system clock; all logic on rising edge
//  reset          in   1   synchronous, active-high
//  ioctl_download in   1   download window active
//  ioctl_wr       in   1   one-cycle byte strobe
//  ioctl_addr     in   25  byte offset within download
//  ioctl_dout     in   8   download byte
//  ioctl_index    in   8   download target index
//  ioctl_wait     out  1   holding register full; HPS must not strobe
//  cpu_req        in   1   level; held until cpu_ack
//  cpu_we         in   1   1 = write, 0 = read; stable while cpu_req
//  cpu_addr       in   16  CPU address
//  cpu_din        in   8   CPU write data
//  cpu_dout       out  8   read data; valid with cpu_ack, held until next read
//  cpu_ack        out  1   one-cycle completion pulse
//  mem_addr       out  16  RAM address (registered)
//  mem_we         out  1   RAM write enable, one-cycle pulse (registered)
//  mem_din        out  8   RAM write data (registered)
//  mem_dout       in   8   RAM read data, valid 1 cycle after the address is presented
//  cpu_hold       out  1   high from start of an accepted download until dn_done
//  dn_done        out  1   one-cycle pulse: download ended and holding register flushed
//  dn_bytes       out  17  bytes written to RAM in the current/last download
//  dn_overrun     out  1   sticky: strobe arrived while holding register was full
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, holding register empty, last_grant = CPU.
//  Capture: ioctl_wr & ioctl_download & ioctl_index==DN_INDEX & ioctl_addr<DN_SIZE & !hold_valid
//    -> latch {addr[15:0], data}; hold_valid = 1; ioctl_wait = hold_valid, registered.
//  Capture while hold_valid -> byte dropped, dn_overrun = 1. Out-of-index/range strobes -> ignored.
//  Download start (rising edge of ioctl_download with matching index)
//    -> dn_bytes = 0, dn_overrun = 0, cpu_hold = 1.
//  FSM states: IDLE, C_ISSUE, C_WAIT, D_ISSUE.
//   IDLE: cpu_pend = cpu_req & !cpu_ack; dn_pend = hold_valid.
//     Both pending -> grant the one not in last_grant. One pending -> grant it.
//     CPU grant: mem_addr = cpu_addr, mem_we = cpu_we, mem_din = cpu_din -> C_ISSUE.
//     DN grant: mem_addr = DN_BASE + hold_addr (16-bit wrap), mem_we = 1, mem_din = hold_data
//       -> D_ISSUE.
//   C_ISSUE: mem_we -> 0 -> C_WAIT.
//   C_WAIT: cpu_dout = mem_dout (reads only); cpu_ack = 1 for one cycle; last_grant = CPU -> IDLE.
//   D_ISSUE: mem_we -> 0; hold_valid = 0; dn_bytes++ (saturate at 17'h1FFFF);
//     last_grant = DN -> IDLE.
//  Latency, uncontended: cpu_req seen in IDLE at cycle T -> RAM access T+1 -> cpu_ack at T+3.
//    Download byte occupies RAM one cycle; ioctl_wait is high for 3 cycles per byte.
//  Capture in the same cycle D_ISSUE clears the holding register: clear wins, then capture is
//    legal (hold_valid is 0 at the next edge); the strobe is accepted one cycle later only if
//    still asserted. HPS obeys ioctl_wait.
//  End: ioctl_download falls -> dn_done pulses the first cycle hold_valid==0; cpu_hold -> 0
//    with it.
//  Mid-operation reset: next edge -> IDLE; pending byte and CPU access abandoned;
//    cpu_ack, mem_we, ioctl_wait = 0.
// STRUCTURE
//  laser310_pkg: FSM state enum; grant_t {GR_CPU, GR_DN}; DN_CNT_W = 17.
//  Sub-module: laser310_dn_hold (1-deep holding register + overrun flag); arbiter/FSM in top.
// TESTING
//  1. Download idx 0, addr 0..3, data A0..A3, no CPU -> writes DN_BASE+0..3 = A0..A3;
//     ioctl_wait 3 cycles/byte; dn_done once; dn_bytes = 4.
//  2. CPU read 0x7000, RAM model returns 0x5A -> cpu_ack at T+3, cpu_dout = 0x5A;
//     CPU write 0x7001 = 0x33 -> single mem_we pulse.
//  3. cpu_req and hold_valid both pending, last_grant = CPU -> DN served first, then CPU;
//     4 contended rounds alternate strictly.
//  4. Strobes with ioctl_index = 1, or ioctl_addr = 0x10000 -> no mem_we, ioctl_wait stays 0,
//     dn_bytes = 0.
//  5. Second ioctl_wr while ioctl_wait = 1 -> byte dropped, dn_overrun = 1;
//     cleared at next download start.
//  6. reset asserted during C_WAIT -> next cycle IDLE; no cpu_ack; mem_we = 0; ioctl_wait = 0.

Source files
------------

// File: rtl/laser310_pkg.sv
// Shared types for the Laser310 RAM arbiter: FSM states, grant owner and the
// download byte-counter width with its saturating increment.
package laser310_pkg;

  localparam int DN_CNT_W = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_C_ISSUE,
    S_C_WAIT,
    S_D_ISSUE
  } state_t;

  typedef enum logic {
    GR_CPU,
    GR_DN
  } grant_t;

  function automatic logic [DN_CNT_W-1:0] sat_inc(input logic [DN_CNT_W-1:0] v);
    return (&v) ? v : v + DN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/laser310_dn_hold.sv
// One-deep holding register for ioctl download bytes, with the HPS back-pressure
// flag and a sticky overrun flag for strobes that arrive while it is full.
module laser310_dn_hold (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        strobe,
  input  logic [15:0] strobe_addr,
  input  logic [7:0]  strobe_data,
  input  logic        clear,
  input  logic        clr_overrun,
  output logic        hold_valid,
  output logic [15:0] hold_addr,
  output logic [7:0]  hold_data,
  output logic        hold_wait,
  output logic        overrun
);

  logic capture;

  assign capture = strobe & ~hold_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_wait  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // clear only happens while full, so it can never meet a capture
      hold_valid <= capture | (hold_valid & ~clear);
      // wait lags the clear by one cycle, giving the HPS a clean gap
      hold_wait  <= capture | hold_valid;
      if (capture) begin
        hold_addr <= strobe_addr;
        hold_data <= strobe_data;
      end
      if (strobe & hold_valid) overrun <= 1'b1;
      else if (clr_overrun)    overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/laser310_dn_arbiter.sv
// Round-robin sharing of the single-port system RAM between the Z80 and the HPS
// ioctl download stream, plus download start/end tracking for the emu top level.
module laser310_dn_arbiter
  import laser310_pkg::*;
#(
  parameter logic [7:0]  DN_INDEX = 8'h00,
  parameter logic [15:0] DN_BASE  = 16'h0000,
  parameter logic [16:0] DN_SIZE  = 17'h10000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  output logic        cpu_hold,
  output logic        dn_done,
  output logic [16:0] dn_bytes,
  output logic        dn_overrun
);

  state_t      state, state_nxt;
  grant_t      last_grant, last_grant_nxt;
  logic        dn_match, dn_strobe, dn_start, dl_prev;
  logic        hold_valid, dn_clear;
  logic [15:0] hold_addr;
  logic [7:0]  hold_data;
  logic        cpu_pend, dn_pend, grant_cpu, grant_dn;
  logic        acc_we, acc_we_nxt;
  logic [15:0] mem_addr_nxt;
  logic [7:0]  mem_din_nxt, cpu_dout_nxt;
  logic        mem_we_nxt, cpu_ack_nxt;

  assign dn_match  = (ioctl_index == DN_INDEX);
  assign dn_strobe = ioctl_wr & ioctl_download & dn_match & (ioctl_addr < 25'(DN_SIZE));
  assign dn_start  = ioctl_download & ~dl_prev & dn_match;

  laser310_dn_hold u_hold (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .strobe      (dn_strobe),
    .strobe_addr (ioctl_addr[15:0]),
    .strobe_data (ioctl_dout),
    .clear       (dn_clear),
    .clr_overrun (dn_start),
    .hold_valid  (hold_valid),
    .hold_addr   (hold_addr),
    .hold_data   (hold_data),
    .hold_wait   (ioctl_wait),
    .overrun     (dn_overrun)
  );

  // The ack cycle masks the CPU so a still-held cpu_req is not served twice.
  assign cpu_pend  = cpu_req & ~cpu_ack;
  assign dn_pend   = hold_valid;
  assign grant_cpu = cpu_pend & (~dn_pend | (last_grant == GR_DN));
  assign grant_dn  = dn_pend & (~cpu_pend | (last_grant == GR_CPU));

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_cpu)     state_nxt = S_C_ISSUE;
        else if (grant_dn) state_nxt = S_D_ISSUE;
      end
      S_C_ISSUE: state_nxt = S_C_WAIT;
      S_C_WAIT:  state_nxt = S_IDLE;
      S_D_ISSUE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    mem_addr_nxt   = mem_addr;
    mem_din_nxt    = mem_din;
    mem_we_nxt     = 1'b0;
    cpu_ack_nxt    = 1'b0;
    cpu_dout_nxt   = cpu_dout;
    last_grant_nxt = last_grant;
    acc_we_nxt     = acc_we;
    dn_clear       = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_cpu) begin
          mem_addr_nxt = cpu_addr;
          mem_we_nxt   = cpu_we;
          mem_din_nxt  = cpu_din;
          acc_we_nxt   = cpu_we;
        end else if (grant_dn) begin
          mem_addr_nxt = DN_BASE + hold_addr;
          mem_we_nxt   = 1'b1;
          mem_din_nxt  = hold_data;
        end
      end
      S_C_WAIT: begin
        if (!acc_we) cpu_dout_nxt = mem_dout;
        cpu_ack_nxt    = 1'b1;
        last_grant_nxt = GR_CPU;
      end
      S_D_ISSUE: begin
        dn_clear       = 1'b1;
        last_grant_nxt = GR_DN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last_grant <= GR_CPU;
      acc_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_dout   <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      acc_we     <= acc_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_din    <= mem_din_nxt;
      mem_we     <= mem_we_nxt;
      cpu_ack    <= cpu_ack_nxt;
      cpu_dout   <= cpu_dout_nxt;
    end
  end

  // Download window: start clears the stats; done fires once the last byte has left.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_prev  <= 1'b0;
      cpu_hold <= 1'b0;
      dn_done  <= 1'b0;
      dn_bytes <= '0;
    end else begin
      dl_prev <= ioctl_download;
      dn_done <= 1'b0;
      if (dn_start) begin
        cpu_hold <= 1'b1;
        dn_bytes <= '0;
      end else begin
        if (dn_clear) dn_bytes <= sat_inc(dn_bytes);
        if (cpu_hold & ~ioctl_download & ~hold_valid) begin
          cpu_hold <= 1'b0;
          dn_done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_laser310_dn_arbiter.sv
// Bench for laser310_dn_arbiter: RAM model, write scoreboard, CPU vector table
// and hand sequences for download, contention, filtering, overrun and reset.
module tb_laser310_dn_arbiter;

  localparam logic [15:0] BASE = 16'hC000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        ioctl_wait;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_ack;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_din, mem_dout;
  logic        cpu_hold, dn_done;
  logic [16:0] dn_bytes;
  logic        dn_overrun;

  always #5 clk_sys = ~clk_sys;

  laser310_dn_arbiter #(
    .DN_INDEX (8'h00),
    .DN_BASE  (BASE),
    .DN_SIZE  (17'h10000)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .cpu_ack        (cpu_ack),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .cpu_hold       (cpu_hold),
    .dn_done        (dn_done),
    .dn_bytes       (dn_bytes),
    .dn_overrun     (dn_overrun)
  );

  logic [7:0] ram [0:65535];

  always @(posedge clk_sys) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        pre;
    logic [7:0]  pre_val;
    logic [7:0]  exp_dout;
  } cpu_vec_t;

  wr_t exp_wr [$];
  int  n_checks  = 0;
  int  n_pass    = 0;
  int  wr_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Every RAM write must match the next expected write, in order.
  always @(negedge clk_sys) begin
    if (mem_we === 1'b1) begin
      wr_pulses++;
      if (exp_wr.size() == 0) begin
        check("wr_unexpected_addr", {16'h0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_din, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ioctl_wait && n < 20) begin
      tick();
      n++;
    end
    check("wait_release", ioctl_wait, 1'b0);
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!cpu_ack && cyc < 20);
    cpu_req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!dn_done && n < 10) begin
      tick();
      n++;
    end
    check("done_seen", dn_done, 1'b1);
    check("done_hold_low", cpu_hold, 1'b0);
  endtask

  initial begin
    cpu_vec_t vec [6];
    int       cyc, n, p0, done_cnt, ack_cnt;

    vec[0] = '{1'b0, 16'h7000, 8'h00, 1'b1, 8'h5A, 8'h5A};
    vec[1] = '{1'b1, 16'h7001, 8'h33, 1'b0, 8'h00, 8'h5A};
    vec[2] = '{1'b0, 16'h7001, 8'h00, 1'b0, 8'h00, 8'h33};
    vec[3] = '{1'b0, 16'hFFFF, 8'h00, 1'b1, 8'hC3, 8'hC3};
    vec[4] = '{1'b1, 16'h0000, 8'h99, 1'b0, 8'h00, 8'hC3};
    vec[5] = '{1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h99};

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    reset = 1'b1;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    tick(3);
    check("rst_ioctl_wait", ioctl_wait, 1'b0);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_cpu_hold", cpu_hold, 1'b0);
    check("rst_dn_done", dn_done, 1'b0);
    check("rst_dn_bytes", dn_bytes, 17'h0);
    check("rst_dn_overrun", dn_overrun, 1'b0);
    reset = 1'b0;
    tick();

    // Plain download of four bytes with no CPU traffic.
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    check("dl1_cpu_hold", cpu_hold, 1'b1);
    check("dl1_bytes_start", dn_bytes, 17'h0);
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      push_wr(BASE + 16'(i), 8'hA0 + 8'(i));
      strobe(25'(i), 8'hA0 + 8'(i));
      n = 0;
      while (ioctl_wait && n < 20) begin
        n++;
        tick();
      end
      check("dl1_wait_cycles", n, 3);
    end
    check("dl1_bytes", dn_bytes, 17'd4);
    ioctl_download = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dn_done) begin
        done_cnt++;
        check("dl1_done_hold", cpu_hold, 1'b0);
      end
    end
    check("dl1_done_pulses", done_cnt, 1);
    check("dl1_bytes_final", dn_bytes, 17'd4);

    // Uncontended CPU accesses from the vector table.
    foreach (vec[i]) begin
      if (vec[i].pre) ram[vec[i].addr] = vec[i].pre_val;
      if (vec[i].we) push_wr(vec[i].addr, vec[i].din);
      p0 = wr_pulses;
      cpu_req = 1'b1; cpu_we = vec[i].we; cpu_addr = vec[i].addr; cpu_din = vec[i].din;
      tick();
      check("cpu_mem_addr", mem_addr, vec[i].addr);
      check("cpu_mem_we", mem_we, vec[i].we);
      wait_ack(cyc);
      check("cpu_ack_latency", cyc + 1, 3);
      check("cpu_dout", cpu_dout, vec[i].exp_dout);
      tick();
      check("cpu_ack_pulse", cpu_ack, 1'b0);
      check("cpu_wr_pulses", wr_pulses - p0, {31'h0, vec[i].we});
    end

    // Contention with last grant CPU: download byte first, then the CPU write.
    ioctl_download = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) begin
      wait_ready();
      push_wr(BASE + 16'h0100 + 16'(r), 8'h10 + 8'(r));
      push_wr(16'h8000 + 16'(r), 8'h20 + 8'(r));
      strobe(25'h100 + 25'(r), 8'h10 + 8'(r));
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8000 + 16'(r); cpu_din = 8'h20 + 8'(r);
      wait_ack(cyc);
      check("rr_dn_first_ack", cyc, 5);
      tick(2);
    end
    check("rr_bytes", dn_bytes, 17'd4);
    // A lone byte leaves last grant at DN, so the next tie goes to the CPU.
    wait_ready();
    push_wr(BASE + 16'h0200, 8'h5E);
    strobe(25'h200, 8'h5E);
    wait_ready();
    push_wr(16'h8010, 8'h6F);
    push_wr(BASE + 16'h0201, 8'h7E);
    strobe(25'h201, 8'h7E);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8010; cpu_din = 8'h6F;
    wait_ack(cyc);
    check("rr_cpu_first_ack", cyc, 3);
    wait_ready();
    check("rr_bytes_total", dn_bytes, 17'd6);
    ioctl_download = 1'b0;
    wait_done();

    // Filtered strobes: wrong index, then out of range; last legal address wraps.
    ioctl_index = 8'h01; ioctl_download = 1'b1;
    tick();
    check("idx_no_hold", cpu_hold, 1'b0);
    p0 = wr_pulses;
    strobe(25'h5, 8'hEE);
    check("idx_wait", ioctl_wait, 1'b0);
    tick(3);
    check("idx_wait_later", ioctl_wait, 1'b0);
    check("idx_bytes_kept", dn_bytes, 17'd6);
    ioctl_download = 1'b0;
    tick();
    ioctl_index = 8'h00; ioctl_download = 1'b1;
    tick();
    check("rng_hold", cpu_hold, 1'b1);
    check("rng_bytes_start", dn_bytes, 17'h0);
    strobe(25'h10000, 8'hEE);
    check("rng_wait", ioctl_wait, 1'b0);
    tick(3);
    check("rng_wait_later", ioctl_wait, 1'b0);
    check("filter_no_wr", wr_pulses - p0, 0);
    check("rng_bytes", dn_bytes, 17'h0);
    push_wr(16'hBFFF, 8'h77);
    strobe(25'hFFFF, 8'h77);
    check("edge_wait", ioctl_wait, 1'b1);
    wait_ready();
    check("edge_bytes", dn_bytes, 17'd1);

    // Overrun: second strobe while the holding register is still full.
    check("ovr_clear", dn_overrun, 1'b0);
    push_wr(BASE + 16'h0020, 8'h55);
    strobe(25'h20, 8'h55);
    strobe(25'h21, 8'h66);
    check("ovr_set", dn_overrun, 1'b1);
    wait_ready();
    check("ovr_bytes", dn_bytes, 17'd2);
    ioctl_download = 1'b0;
    wait_done();
    check("ovr_sticky", dn_overrun, 1'b1);
    ioctl_download = 1'b1;
    tick();
    check("ovr_cleared_at_start", dn_overrun, 1'b0);
    ioctl_download = 1'b0;
    wait_done();

    // Reset while a CPU read sits in C_WAIT with a byte held.
    ioctl_download = 1'b1;
    tick();
    ram[16'h7100] = 8'hA5;
    p0 = wr_pulses;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h7100;
    tick();
    strobe(25'h30, 8'hBB);
    check("prerst_wait", ioctl_wait, 1'b1);
    reset = 1'b1; cpu_req = 1'b0; ioctl_download = 1'b0;
    tick();
    check("rst_mid_ack", cpu_ack, 1'b0);
    check("rst_mid_mem_we", mem_we, 1'b0);
    check("rst_mid_wait", ioctl_wait, 1'b0);
    check("rst_mid_hold", cpu_hold, 1'b0);
    check("rst_mid_dout", cpu_dout, 8'h00);
    check("rst_mid_bytes", dn_bytes, 17'h0);
    reset = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack) ack_cnt++;
    end
    check("rst_no_ack", ack_cnt, 0);
    check("rst_no_wr", wr_pulses - p0, 0);
    check("rst_wait_idle", ioctl_wait, 1'b0);

    check("wr_queue_empty", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
